wb_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline write-back stage and one long-latency unit (divider / multi-cycle load return).
- Pipeline writes have priority.
- Long-latency (LL) results wait in a small holding FIFO and drain on free write-port cycles.
- A starvation counter forces a one-cycle pipeline stall so the FIFO always drains.
- The block sits between the write-back stage and the register file; it also exports a pending-rd mask for hazard logic.

---
 rtl/wb_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority; long-latency results queue in a small FIFO.
// Latency 1 cycle to rf_*; ll_ready drops when the FIFO is full; pipe_stall forces a drain after STARVE_MAX blocked cycles. Optional WB_ARB_PERF_EN adds counters.
module wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        pipe_valid,
    input  logic        pipe_Wreg,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_Wdata,
    output logic        pipe_stall,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_Wdata,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_Wdata,
    output logic [31:0] busy_mask
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] ll_wr_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       rd_q  [DEPTH];
    logic [31:0]      dat_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve;

    logic pipe_wr;
    logic head_v;
    logic force_ll;
    logic grant_ll;
    logic grant_pipe;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pipe_wr    = pipe_valid && pipe_Wreg && (pipe_rd != 5'd0);
    assign head_v     = (count != '0);
    assign force_ll   = head_v && (starve == SW'(STARVE_MAX));
    assign grant_ll   = force_ll || (!pipe_wr && head_v);
    assign grant_pipe = pipe_wr && !force_ll;
    assign pipe_stall = force_ll && pipe_wr;
    assign ll_ready   = (count < CW'(DEPTH));
    // rd 0 results complete the handshake but never occupy a slot.
    assign push       = ll_valid && ll_ready && (ll_rd != 5'd0);
    assign pop        = grant_ll;

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) busy_mask[rd_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            rd_q[wptr]  <= ll_rd;
            dat_q[wptr] <= ll_Wdata;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            vld_q  <= '0;
            rptr   <= '0;
            wptr   <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            if (pop) begin
                vld_q[rptr] <= 1'b0;
                rptr        <= next_ptr(rptr);
            end
            if (push) begin
                vld_q[wptr] <= 1'b1;
                wptr        <= next_ptr(wptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop || !head_v)
                starve <= '0;
            else if (grant_pipe && (starve != SW'(STARVE_MAX)))
                starve <= starve + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_Wdata <= '0;
        end else begin
            rf_we <= grant_ll || grant_pipe;
            if (grant_ll) begin
                rf_rd    <= rd_q[rptr];
                rf_Wdata <= dat_q[rptr];
            end else if (grant_pipe) begin
                rf_rd    <= pipe_rd;
                rf_Wdata <= pipe_Wdata;
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stall_cnt <= '0;
            ll_wr_cnt <= '0;
        end else begin
            if (pipe_stall) stall_cnt <= stall_cnt + 32'd1;
            if (grant_ll)   ll_wr_cnt <= ll_wr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        Clock;
    logic        nReset;
    logic        pipe_valid;
    logic        pipe_Wreg;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_Wdata;
    logic        pipe_stall;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_Wdata;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_Wdata;
    logic [31:0] busy_mask;
`ifdef WB_ARB_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] ll_wr_cnt;
`endif

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .Clock(Clock), .nReset(nReset),
        .pipe_valid(pipe_valid), .pipe_Wreg(pipe_Wreg), .pipe_rd(pipe_rd), .pipe_Wdata(pipe_Wdata),
        .pipe_stall(pipe_stall),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_Wdata(ll_Wdata),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_Wdata(rf_Wdata), .busy_mask(busy_mask)
`ifdef WB_ARB_PERF_EN
        , .stall_cnt(stall_cnt), .ll_wr_cnt(ll_wr_cnt)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_dat;
    int          m_stalls;
    int          m_llw;
    int          n_tests;
    int          n_fail;

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        exp_we   = 1'b0;
        exp_rd   = '0;
        exp_dat  = '0;
        m_stalls = 0;
        m_llw    = 0;
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic step(output bit stalled, output bit ll_acc);
        bit          pw;
        bit          fl;
        bit          gl;
        bit          gp;
        bit          exp_rdy;
        logic [31:0] eb;
        ent_t        e;
        #1;
        pw      = pipe_valid && pipe_Wreg && (pipe_rd != 5'd0);
        fl      = (mq.size() > 0) && (m_starve == STARVE_MAX);
        stalled = fl && pw;
        exp_rdy = (mq.size() < DEPTH);
        eb = '0;
        foreach (mq[i]) eb[mq[i].rd] = 1'b1;
        n_tests++;
        if (pipe_stall !== stalled) begin
            n_fail++;
            $display("FAIL pipe_stall t=%0t got %0b exp %0b", $time, pipe_stall, stalled);
        end
        n_tests++;
        if (ll_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL ll_ready t=%0t got %0b exp %0b", $time, ll_ready, exp_rdy);
        end
        n_tests++;
        if (busy_mask !== eb) begin
            n_fail++;
            $display("FAIL busy_mask t=%0t got %h exp %h", $time, busy_mask, eb);
        end
        ll_acc = ll_valid && exp_rdy;
        gl = fl || (!pw && mq.size() > 0);
        gp = pw && !fl;
        if (gl) begin
            exp_we  = 1'b1;
            exp_rd  = mq[0].rd;
            exp_dat = mq[0].d;
            void'(mq.pop_front());
            m_llw++;
            m_starve = 0;
        end else begin
            exp_we = gp;
            if (gp) begin
                exp_rd  = pipe_rd;
                exp_dat = pipe_Wdata;
            end
            if (mq.size() == 0) m_starve = 0;
            else if (gp && m_starve < STARVE_MAX) m_starve++;
        end
        if (stalled) m_stalls++;
        if (ll_acc && ll_rd != 5'd0) begin
            e.rd = ll_rd;
            e.d  = ll_Wdata;
            mq.push_back(e);
        end
        @(posedge Clock);
        #1;
        n_tests++;
        if (rf_we !== exp_we || rf_rd !== exp_rd || rf_Wdata !== exp_dat) begin
            n_fail++;
            $display("FAIL rf_port t=%0t got we=%0b rd=%0d d=%h exp we=%0b rd=%0d d=%h",
                     $time, rf_we, rf_rd, rf_Wdata, exp_we, exp_rd, exp_dat);
        end
        @(negedge Clock);
    endtask

    task automatic idle_inputs();
        pipe_valid = 0; pipe_Wreg = 0; pipe_rd = 0; pipe_Wdata = 0;
        ll_valid = 0; ll_rd = 0; ll_Wdata = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_Wdata !== 32'd0 || busy_mask !== 32'd0 ||
            ll_ready !== 1'b1 || pipe_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got we=%0b rd=%0d d=%h busy=%h rdy=%0b stall=%0b exp 0,0,0,0,1,0",
                     tag, rf_we, rf_rd, rf_Wdata, busy_mask, ll_ready, pipe_stall);
        end
    endtask

    task automatic test_reset();
        bit s, a;
        idle_inputs();
        nReset = 1'b0;
        #12;
        check_reset_outputs("reset_state");
        @(negedge Clock);
        nReset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step(s, a);
    endtask

    task automatic test_pipe_write();
        bit s, a;
        pipe_valid = 1; pipe_Wreg = 1; pipe_rd = 5; pipe_Wdata = 32'hDEADBEEF;
        step(s, a);
        n_tests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_Wdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL pipe_write got we=%0b rd=%0d d=%h exp 1,5,deadbeef", rf_we, rf_rd, rf_Wdata);
        end
        pipe_rd = 0;
        step(s, a);
        n_tests++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL pipe_rd0 got we=%0b exp 0", rf_we);
        end
        pipe_rd = 3; pipe_Wreg = 0;
        step(s, a);
        idle_inputs();
        step(s, a);
    endtask

    task automatic test_ll_single();
        bit s, a;
        ll_valid = 1; ll_rd = 7; ll_Wdata = 32'h1234;
        step(s, a);
        idle_inputs();
        n_tests++;
        if (busy_mask !== 32'h80) begin
            n_fail++;
            $display("FAIL ll_busy got %h exp 00000080", busy_mask);
        end
        step(s, a);
        n_tests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_Wdata !== 32'h1234) begin
            n_fail++;
            $display("FAIL ll_write got we=%0b rd=%0d d=%h exp 1,7,1234", rf_we, rf_rd, rf_Wdata);
        end
        step(s, a);
        n_tests++;
        if (busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL ll_busy_clear got %h exp 0", busy_mask);
        end
        step(s, a);
    endtask

    // Pipeline writes every cycle; the held instruction is re-presented while stalled.
    task automatic test_starvation();
        bit s, a;
        int nstall;
        nstall = 0;
        pipe_valid = 1; pipe_Wreg = 1; pipe_rd = 1; pipe_Wdata = $urandom;
        ll_valid = 1; ll_rd = 9; ll_Wdata = 32'h9999;
        for (int c = 0; c < 10; c++) begin
            step(s, a);
            if (a) ll_valid = 0;
            if (s) nstall++;
            else begin
                pipe_rd = pipe_rd + 1;
                pipe_Wdata = $urandom;
            end
        end
        n_tests++;
        if (nstall != 1) begin
            n_fail++;
            $display("FAIL starve_stall_count got %0d exp 1", nstall);
        end
        idle_inputs();
        step(s, a);
    endtask

    task automatic test_fifo_full();
        bit s, a;
        int idx;
        int budget;
        logic [4:0] rds [3];
        rds[0] = 11; rds[1] = 12; rds[2] = 13;
        idx = 0;
        budget = 0;
        pipe_valid = 1; pipe_Wreg = 1; pipe_rd = 20; pipe_Wdata = $urandom;
        while (idx < 3 && budget < 30) begin
            ll_valid = 1; ll_rd = rds[idx]; ll_Wdata = 32'hA000 + idx;
            step(s, a);
            budget++;
            if (a) idx++;
            if (!s) begin
                pipe_rd = (pipe_rd == 31) ? 5'd20 : pipe_rd + 1;
                pipe_Wdata = $urandom;
            end
        end
        ll_valid = 0;
        n_tests++;
        if (idx != 3) begin
            n_fail++;
            $display("FAIL fifo_full_accept got %0d accepted exp 3", idx);
        end
        for (int c = 0; c < 15; c++) begin
            step(s, a);
            if (!s) begin
                pipe_rd = (pipe_rd == 31) ? 5'd20 : pipe_rd + 1;
                pipe_Wdata = $urandom;
            end
        end
        n_tests++;
        if (m_llw < 3 || mq.size() != 0) begin
            n_fail++;
            $display("FAIL fifo_drain got pending=%0d exp 0", mq.size());
        end
        idle_inputs();
        step(s, a);
    endtask

    task automatic test_reset_mid();
        bit s, a;
        int budget;
        budget = 0;
        pipe_valid = 1; pipe_Wreg = 1; pipe_rd = 2; pipe_Wdata = $urandom;
        ll_valid = 1; ll_rd = 14; ll_Wdata = 32'h14;
        step(s, a);
        ll_rd = 15; ll_Wdata = 32'h15;
        step(s, a);
        ll_valid = 0;
        while (!(mq.size() == 2 && m_starve == STARVE_MAX) && budget < 10) begin
            step(s, a);
            budget++;
        end
        n_tests++;
        if (mq.size() != 2 || m_starve != STARVE_MAX) begin
            n_fail++;
            $display("FAIL reset_mid_setup got entries=%0d starve=%0d exp 2,%0d", mq.size(), m_starve, STARVE_MAX);
        end
        nReset = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(negedge Clock);
        nReset = 1'b1;
        model_reset();
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            step(s, a);
            n_tests++;
            if (rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_discard got we=%0b rd=%0d exp we=0", rf_we, rf_rd);
            end
        end
    endtask

    task automatic test_random();
        bit s, a;
        s = 0; a = 0;
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            if (!s) begin
                pipe_valid = ($urandom_range(0, 9) < 7);
                pipe_Wreg  = ($urandom_range(0, 9) < 8);
                pipe_rd    = 5'($urandom_range(0, 31));
                pipe_Wdata = $urandom;
            end
            if (!ll_valid || a) begin
                ll_valid = ($urandom_range(0, 9) < 4);
                ll_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ll_Wdata = $urandom;
            end
            step(s, a);
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) step(s, a);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        test_reset();
        test_pipe_write();
        test_ll_single();
        test_starvation();
        test_fifo_full();
        test_reset_mid();
        test_random();
`ifdef WB_ARB_PERF_EN
        n_tests++;
        if (stall_cnt !== 32'(m_stalls) || ll_wr_cnt !== 32'(m_llw)) begin
            n_fail++;
            $display("FAIL perf_counters got stall=%0d llw=%0d exp stall=%0d llw=%0d",
                     stall_cnt, ll_wr_cnt, m_stalls, m_llw);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
